// File: rtl/bloom_age_sweeper.sv
// Bloom filter aging sweeper: read, right-shift by SHIFT_AMT, write back each word of a region; optional rd_vld watchdog via BLOOM_SWEEP_TIMEOUT_EN.
// Per word: read ack + read pipeline + 1 capture + write ack + 1; requests stay low while enable=0 and drop on their own ack.
module bloom_age_sweeper #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int BASE_ADDR       = 0,
    parameter int NUM_WORDS       = 1024,
    parameter int SHIFT_AMT       = 1,
    parameter int PERIOD_WIDTH    = 32,
    parameter int TIMEOUT         = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [PERIOD_WIDTH-1:0]    sweep_period,
    input  logic                       sweep_start,
    output logic                       rd_req,
    output logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
    input  logic                       rd_ack,
    input  logic                       rd_vld,
    input  logic [SRAM_DATA_WIDTH-1:0] rd_data,
    output logic                       wr_req,
    output logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
    output logic [SRAM_DATA_WIDTH-1:0] wr_data,
    input  logic                       wr_ack,
    output logic                       busy,
    output logic                       sweep_done,
    output logic [31:0]                sweep_count,
    output logic                       timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        NEXT
    } state_t;

    localparam logic [SRAM_ADDR_WIDTH-1:0] FIRST_ADDR = SRAM_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [SRAM_ADDR_WIDTH-1:0] LAST_ADDR  = SRAM_ADDR_WIDTH'(BASE_ADDR + NUM_WORDS - 1);

    state_t                      state_q, state_d;
    logic [SRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0]  data_q, data_d;
    logic [PERIOD_WIDTH-1:0]     timer_q, timer_d;
    logic                        pending_q, pending_d;
    logic [31:0]                 count_q, count_d;
    logic                        timer_fire;
    logic                        consume;
    logic                        done;
    logic                        wd_expire;

    // Period timer: a shrunken period that the timer already passed just restarts it.
    always_comb begin
        timer_d    = timer_q;
        timer_fire = 1'b0;
        if (sweep_period == '0) begin
            timer_d = '0;
        end else if (timer_q >= sweep_period) begin
            timer_d = '0;
        end else if (enable) begin
            if (timer_q == sweep_period - PERIOD_WIDTH'(1)) begin
                timer_d    = '0;
                timer_fire = 1'b1;
            end else begin
                timer_d = timer_q + PERIOD_WIDTH'(1);
            end
        end
    end

    assign consume = (state_q == IDLE) && pending_q && enable;

    // A trigger landing on the consume cycle is kept, so it becomes the follow-up sweep.
    always_comb begin
        pending_d = pending_q;
        if (wd_expire) begin
            pending_d = 1'b0;
        end else if (sweep_start || timer_fire) begin
            pending_d = 1'b1;
        end else if (consume) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (consume) begin
                    addr_d  = FIRST_ADDR;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                rd_req = enable & ~rd_ack;
                if (enable && rd_ack) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_vld) begin
                    data_d  = rd_data >> SHIFT_AMT;
                    state_d = WR_REQ;
                end else if (wd_expire) begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                wr_req = enable & ~wr_ack;
                if (enable && wr_ack) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (enable) begin
                    if (addr_q == LAST_ADDR) begin
                        done    = 1'b1;
                        count_d = count_q + 32'd1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + SRAM_ADDR_WIDTH'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= FIRST_ADDR;
            data_q    <= '0;
            timer_q   <= '0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

`ifdef BLOOM_SWEEP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    always_comb begin
        wd_d      = '0;
        wd_expire = 1'b0;
        if (state_q == RD_WAIT && !rd_vld) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                wd_expire = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
        err_d = err_q | wd_expire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Address/data buses are zero outside their request states so reset leaves every output at 0.
    assign rd_addr     = (state_q == RD_REQ) ? addr_q : '0;
    assign wr_addr     = (state_q == WR_REQ) ? addr_q : '0;
    assign wr_data     = (state_q == WR_REQ) ? data_q : '0;
    assign busy        = (state_q != IDLE);
    assign sweep_done  = done;
    assign sweep_count = count_q;

endmodule

// File: tb/tb_bloom_age_sweeper.sv
// Self-checking bench: SRAM/arbiter model with configurable ack delay and 4-cycle read pipeline; memory contents checked against shift-per-sweep rule.
module tb_bloom_age_sweeper;

    localparam int AW = 19;
    localparam int DW = 72;
    localparam int BASE = 16;
    localparam int NW = 4;
    localparam int SH = 1;
    localparam int PW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [PW-1:0] sweep_period = '0;
    logic          sweep_start = 1'b0;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack = 1'b0;
    logic          rd_vld = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack = 1'b0;
    logic          busy;
    logic          sweep_done;
    logic [31:0]   sweep_count;
    logic          timeout_err;

    always #5 clk = ~clk;

    bloom_age_sweeper #(
        .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .BASE_ADDR(BASE), .NUM_WORDS(NW),
        .SHIFT_AMT(SH), .PERIOD_WIDTH(PW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(rst), .enable(enable), .sweep_period(sweep_period),
        .sweep_start(sweep_start), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_vld(rd_vld), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .sweep_done(sweep_done),
        .sweep_count(sweep_count), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // SRAM + arbiter model
    logic [DW-1:0] mem [int];
    logic [DW-1:0] rd_val [int];
    logic [DW-1:0] orig [NW];
    int  ack_dly_rd = 0, ack_dly_wr = 0;
    bit  suppress_vld = 0;
    int  cyc = 0, rd_wait = 0, wr_wait = 0, rd_pipe = 0, pend_addr = 0;
    int  rd_log[$], wr_log[$], busy_rise[$];
    int  done_cnt = 0, rd_req_cnt = 0, wr_req_cnt = 0, last_ack_cyc = 0;
    bit  busy_prev = 0;

    always @(negedge clk) begin
        bit s_rd, s_wr, s_busy, s_done;
        int a;
        logic [DW-1:0] exp;
        s_rd = rd_req; s_wr = wr_req; s_busy = busy; s_done = sweep_done;
        cyc++;
        rd_ack = 1'b0; wr_ack = 1'b0; rd_vld = 1'b0;
        if (rst) begin
            rd_wait = 0; wr_wait = 0; rd_pipe = 0; busy_prev = 0;
        end else begin
            n_cmp++;
            if (s_rd && s_wr) begin
                n_bad++;
                $display("FAIL req_overlap: rd_req=%0b wr_req=%0b required not both 1 at cyc %0d", s_rd, s_wr, cyc);
            end
            if (s_done) done_cnt++;
            if (s_busy && !busy_prev) busy_rise.push_back(cyc);
            busy_prev = s_busy;
            if (rd_pipe > 0) begin
                rd_pipe--;
                if (rd_pipe == 0 && !suppress_vld) begin
                    rd_vld = 1'b1;
                    rd_data = mem.exists(pend_addr) ? mem[pend_addr] : '0;
                    rd_val[pend_addr] = rd_data;
                end
            end
            if (s_rd) begin
                rd_req_cnt++;
                if (rd_wait >= ack_dly_rd) begin
                    rd_ack = 1'b1; rd_wait = 0;
                    pend_addr = int'(rd_addr);
                    rd_log.push_back(pend_addr);
                    rd_pipe = 4; last_ack_cyc = cyc;
                end else rd_wait++;
            end
            if (s_wr) begin
                wr_req_cnt++;
                if (wr_wait >= ack_dly_wr) begin
                    wr_ack = 1'b1; wr_wait = 0;
                    a = int'(wr_addr);
                    wr_log.push_back(a);
                    exp = rd_val.exists(a) ? (rd_val[a] >> SH) : {DW{1'bx}};
                    n_cmp++;
                    if (wr_data !== exp) begin
                        n_bad++;
                        $display("FAIL wr_data @%0h: got %h required %h", a, wr_data, exp);
                    end
                    mem[a] = wr_data;
                end else wr_wait++;
            end
        end
        if (rd_ack || wr_ack) begin
            #1;
            n_cmp++;
            if ((rd_ack && rd_req) || (wr_ack && wr_req)) begin
                n_bad++;
                $display("FAIL req_drop_on_ack: rd_req=%0b wr_req=%0b required 0 while acked", rd_req, wr_req);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; sweep_start = 1'b0; sweep_period = '0;
        suppress_vld = 0; ack_dly_rd = 0; ack_dly_wr = 0;
        repeat (2) @(negedge clk);
        rd_log.delete(); wr_log.delete(); busy_rise.delete(); rd_val.delete();
        done_cnt = 0; rd_req_cnt = 0; wr_req_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic preload();
        logic [95:0] r;
        for (int i = 0; i < NW; i++) begin
            r = {$urandom, $urandom, $urandom};
            orig[i] = (i == 0) ? {DW{1'b1}} : r[DW-1:0];
            mem[BASE + i] = orig[i];
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); sweep_start = 1'b1;
        @(negedge clk); sweep_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); n++;
        end
        n_cmp++;
        if (done_cnt < target) begin
            n_bad++;
            $display("FAIL %s_timeout: sweeps done %0d required %0d", name, done_cnt, target);
        end
    endtask

    task automatic check_mem(input int shifts, input string name);
        for (int i = 0; i < NW; i++) begin
            n_cmp++;
            if (mem[BASE + i] !== (orig[i] >> (SH * shifts))) begin
                n_bad++;
                $display("FAIL %s_mem[%0d]: got %h required %h", name, i, mem[BASE + i], orig[i] >> (SH * shifts));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rd_req, wr_req, busy, sweep_done, timeout_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b required 00000", {rd_req, wr_req, busy, sweep_done, timeout_err});
        end
        n_cmp++;
        if (rd_addr !== '0 || wr_addr !== '0) begin
            n_bad++; $display("FAIL reset_addr: rd %h wr %h required 0", rd_addr, wr_addr);
        end
        n_cmp++;
        if (wr_data !== '0 || sweep_count !== 32'd0) begin
            n_bad++; $display("FAIL reset_data: wr_data %h count %0d required 0", wr_data, sweep_count);
        end
        do_reset();
        enable = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rd_req_cnt != 0) begin
            n_bad++; $display("FAIL idle_no_trigger: busy %b reads %0d required 0", busy, rd_req_cnt);
        end
    endtask

    task automatic test_single_sweep();
        do_reset(); enable = 1'b1; preload();
        pulse_start();
        wait_done(1, 300, "single");
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rd_log.size() != NW || wr_log.size() != NW) begin
            n_bad++; $display("FAIL single_nops: reads %0d writes %0d required %0d", rd_log.size(), wr_log.size(), NW);
        end else begin
            for (int i = 0; i < NW; i++) begin
                n_cmp++;
                if (rd_log[i] != BASE + i || wr_log[i] != BASE + i) begin
                    n_bad++; $display("FAIL single_addr[%0d]: rd %0h wr %0h required %0h", i, rd_log[i], wr_log[i], BASE + i);
                end
            end
        end
        check_mem(1, "single");
        n_cmp++;
        if (mem[BASE] !== 72'h7F_FFFF_FFFF_FFFF_FFFF) begin
            n_bad++; $display("FAIL single_allones: got %h required 7fffffffffffffffff", mem[BASE]);
        end
        n_cmp++;
        if (done_cnt != 1 || sweep_count !== 32'd1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_status: done %0d count %0d busy %b required 1 1 0", done_cnt, sweep_count, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(); enable = 1'b1; preload();
        pulse_start();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL merge_busy: got %b required 1", busy);
        end
        wait_done(2, 600, "merge");
        repeat (100) @(negedge clk);
        n_cmp++;
        if (done_cnt != 2 || sweep_count !== 32'd2 || rd_log.size() != 2 * NW) begin
            n_bad++; $display("FAIL merge_count: done %0d count %0d reads %0d required 2 2 %0d", done_cnt, sweep_count, rd_log.size(), 2 * NW);
        end
        check_mem(2, "merge");
    endtask

    task automatic test_enable_gate();
        do_reset(); preload();
        pulse_start();
        repeat (50) @(negedge clk);
        n_cmp++;
        if (rd_req_cnt != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL en_low: reads %0d busy %b required 0 0", rd_req_cnt, busy);
        end
        @(negedge clk); enable = 1'b1;
        @(negedge clk); #2;
        n_cmp++;
        if (rd_req_cnt != 1) begin
            n_bad++; $display("FAIL en_first_req: rd_req samples %0d required 1 one cycle after enable", rd_req_cnt);
        end
        wait_done(1, 300, "en");
        repeat (5) @(negedge clk);
        n_cmp++;
        if (sweep_count !== 32'd1) begin
            n_bad++; $display("FAIL en_count: got %0d required 1", sweep_count);
        end
        check_mem(1, "en");
    endtask

    task automatic test_ack_delay();
        do_reset(); enable = 1'b1; preload();
        ack_dly_rd = 3; ack_dly_wr = 3;
        pulse_start();
        wait_done(1, 500, "ackdly");
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rd_log.size() != NW || rd_req_cnt != 4 * NW) begin
            n_bad++; $display("FAIL ackdly_reads: reads %0d req samples %0d required %0d %0d", rd_log.size(), rd_req_cnt, NW, 4 * NW);
        end else begin
            for (int i = 0; i < NW; i++) begin
                n_cmp++;
                if (rd_log[i] != BASE + i) begin
                    n_bad++; $display("FAIL ackdly_addr[%0d]: got %0h required %0h", i, rd_log[i], BASE + i);
                end
            end
        end
        check_mem(1, "ackdly");
        ack_dly_rd = 0; ack_dly_wr = 0;
    endtask

    task automatic test_period();
        int t0;
        do_reset(); enable = 1'b1; preload();
        @(negedge clk); sweep_period = PW'(100); #2; t0 = cyc;
        wait_done(3, 400, "period");
        repeat (2) @(negedge clk);
        sweep_period = '0;
        repeat (250) @(negedge clk);
        n_cmp++;
        if (busy_rise.size() != 3 || sweep_count !== 32'd3) begin
            n_bad++; $display("FAIL period_count: starts %0d count %0d required 3 3", busy_rise.size(), sweep_count);
        end else begin
            n_cmp++;
            if (busy_rise[0] - t0 < 99 || busy_rise[0] - t0 > 102) begin
                n_bad++; $display("FAIL period_first: %0d cycles required ~100", busy_rise[0] - t0);
            end
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (busy_rise[i] - busy_rise[i-1] != 100) begin
                    n_bad++; $display("FAIL period_gap[%0d]: %0d required 100", i, busy_rise[i] - busy_rise[i-1]);
                end
            end
        end
        check_mem(3, "period");
    endtask

    task automatic test_timeout();
        do_reset(); enable = 1'b1; preload();
        suppress_vld = 1;
        pulse_start();
`ifdef BLOOM_SWEEP_TIMEOUT_EN
        begin
            int n = 0;
            while (timeout_err !== 1'b1 && n < 100) begin
                @(negedge clk); n++;
            end
            n_cmp++;
            if (timeout_err !== 1'b1 || cyc - last_ack_cyc < 15 || cyc - last_ack_cyc > 19) begin
                n_bad++; $display("FAIL to_err: err %b after %0d cycles required 1 after ~%0d", timeout_err, cyc - last_ack_cyc, TO);
            end
            repeat (20) @(negedge clk);
            n_cmp++;
            if (timeout_err !== 1'b1 || busy !== 1'b0 || sweep_count !== 32'd0 || done_cnt != 0) begin
                n_bad++; $display("FAIL to_abort: err %b busy %b count %0d done %0d required 1 0 0 0", timeout_err, busy, sweep_count, done_cnt);
            end
        end
`else
        repeat (60) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || timeout_err !== 1'b0 || rd_log.size() != 1 || done_cnt != 0) begin
            n_bad++; $display("FAIL to_wait: busy %b err %b reads %0d done %0d required 1 0 1 0", busy, timeout_err, rd_log.size(), done_cnt);
        end
`endif
        do_reset();
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL to_clear: got %b required 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        do_reset(); enable = 1'b1; preload();
        ack_dly_wr = 20;
        pulse_start();
        while (wr_req_cnt == 0 && n < 100) begin
            @(negedge clk); n++;
        end
        n_cmp++;
        if (wr_req_cnt == 0) begin
            n_bad++; $display("FAIL rstwr_no_write: wr_req samples 0 required >0");
        end
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++;
        if ({rd_req, wr_req, busy, sweep_done} !== 4'b0 || rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            n_bad++; $display("FAIL rstwr_outputs: ctl %b wr_addr %h wr_data %h required all 0", {rd_req, wr_req, busy, sweep_done}, wr_addr, wr_data);
        end
        repeat (3) @(negedge clk);
        ack_dly_wr = 0; rd_req_cnt = 0; wr_req_cnt = 0;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (rd_req_cnt != 0 || wr_req_cnt != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstwr_quiet: reads %0d writes %0d busy %b required 0 0 0", rd_req_cnt, wr_req_cnt, busy);
        end
        n_cmp++;
        if (mem[BASE] !== orig[0]) begin
            n_bad++; $display("FAIL rstwr_word: got %h required %h", mem[BASE], orig[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_back_to_back();
        test_enable_gate();
        test_ack_delay();
        test_period();
        test_timeout();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/bloom_age_sweeper.md
Name: bloom_age_sweeper

Overview:
- Periodic aging controller for the SRAM-resident Bloom filter.
- Owns requester port 1 (rd_1/wr_1) of the SRAM arbiter.
- Walks a word range: reads each word, right-shifts it by SHIFT_AMT (zero fill), writes it back, so stale entries decay.
- Sweeps start on a programmable period timer or on a software start pulse.

Parameters:
- SRAM_ADDR_WIDTH, 19: SRAM word address width.
- SRAM_DATA_WIDTH, 72: SRAM word width.
- BASE_ADDR, 0: first word address of the swept region.
- NUM_WORDS, 1024: words per sweep; must be ≥1; BASE_ADDR+NUM_WORDS-1 must not exceed 2^SRAM_ADDR_WIDTH-1.
- SHIFT_AMT, 1: right-shift applied to each word; range 1..SRAM_DATA_WIDTH-1.
- PERIOD_WIDTH, 32: width of the period timer and sweep_period.
- TIMEOUT, 16: rd_vld watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- enable  in  1  arbiter ready (low during SRAM init); no request is issued while low.
- sweep_period  in  PERIOD_WIDTH  cycles between automatic sweep triggers; 0 disables the timer.
- sweep_start  in  1  one-cycle software trigger.
- rd_req  out  1  read request to the arbiter.
- rd_addr  out  SRAM_ADDR_WIDTH  read address.
- rd_ack  in  1  read accepted.
- rd_vld  in  1  read data valid.
- rd_data  in  SRAM_DATA_WIDTH  read data.
- wr_req  out  1  write request to the arbiter.
- wr_addr  out  SRAM_ADDR_WIDTH  write address.
- wr_data  out  SRAM_DATA_WIDTH  write data.
- wr_ack  in  1  write accepted.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when the last word's write is acked.
- sweep_count  out  32  completed sweeps, wraps at 2^32.
- timeout_err  out  1  sticky watchdog error; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (asynchronous): state IDLE, timer 0, pending 0, addr BASE_ADDR, data register 0.
- All outputs reset to 0; the sweep in flight is abandoned. The current word is left either unmodified or fully rewritten, never partially written.
- Timer:
  - Increments each cycle while enable=1 and sweep_period≠0.
  - When it reaches sweep_period-1 it returns to 0 and sets pending.
  - Writing sweep_period resets nothing; the timer clears when it is ≥ the new period.
- sweep_start also sets pending.
- pending is one bit: triggers arriving while pending=1 or busy=1 merge into one follow-up sweep.
- FSM:
  - IDLE: if pending and enable, clear pending, load addr=BASE_ADDR, busy=1, go to RD_REQ.
  - RD_REQ:
    - rd_req = enable & ~rd_ack (combinational gate), so the arbiter never accepts twice.
    - rd_addr = addr, stable while requesting.
    - On rd_ack go to RD_WAIT.
  - RD_WAIT: on rd_vld capture data = rd_data >> SHIFT_AMT, go to WR_REQ. rd_vld outside RD_WAIT is ignored.
  - WR_REQ:
    - wr_req = enable & ~wr_ack; wr_addr = addr; wr_data = captured data.
    - On wr_ack go to NEXT.
  - NEXT:
    - If addr = BASE_ADDR+NUM_WORDS-1: pulse sweep_done, increment sweep_count, busy=0, go to IDLE.
    - Otherwise addr+1, go to RD_REQ.
- Read-to-write latency per word: ack + arbiter read pipeline (4 cycles) + 1 capture + write ack + 1.
- rd_req and wr_req are never high in the same cycle.
- enable low mid-sweep: the FSM holds in its current state; an outstanding rd_vld is still captured.
- sweep_start coinciding with the final NEXT cycle sets pending; the next sweep starts from IDLE one cycle later.

Optional Feature:
- Macro BLOOM_SWEEP_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_WAIT.
  - If rd_vld is absent for TIMEOUT cycles: set timeout_err (sticky until reset), abort the sweep (busy=0, no sweep_done, sweep_count unchanged), return to IDLE, clear pending.
- Undefined: no counter; RD_WAIT waits indefinitely; timeout_err constant 0.

Test Plan:
- NUM_WORDS=4, BASE_ADDR=0x10, words preloaded 0x…FF, sweep_start pulse → reads at 0x10..0x13, each followed by a write of 0x…7F to the same address; one sweep_done; sweep_count=1; busy low after.
- sweep_period=100, enable=1, no sweep_start → busy rises 100 cycles after period programmed, then every 100 cycles while sweeps fit; sweep_count=3 after three periods.
- sweep_start pulsed 3 times during a sweep → exactly one extra sweep; sweep_count=2.
- enable held 0 for 50 cycles after reset with sweep_start → no rd_req; first rd_req the cycle after enable=1.
- Arbiter holds rd_ack 3 cycles after request → exactly one read per address; rd_req drops the same cycle rd_ack rises.
- BLOOM_SWEEP_TIMEOUT_EN, TIMEOUT=16, rd_vld suppressed → timeout_err=1 after 16 cycles in RD_WAIT, busy=0, sweep_count unchanged.
- Reset asserted mid-WR_REQ → all outputs 0 immediately, no further requests.
